// File: rtl/wptr_full_level.sv
// ---------------------------------------------------------------------------
// wptr_full_level
//
// Write-side pointer and status logic for an asynchronous FIFO. It keeps the
// binary and Gray write pointers and derives registered full, almost-full and
// fill-level flags from the synchronised Gray read pointer. It also keeps a
// sticky overflow flag for writes attempted while full.
//
// Parameters
//   addr_width  log2 of FIFO depth (D = 2**addr_width), legal 2..12
//
// Ports
//   wclk        write-domain clock
//   wrst_n      asynchronous active-low reset
//   winc        write request this cycle (ignored while wfull=1)
//   wq2_rptr    Gray read pointer, already synchronised into wclk
//   wafull_lvl  almost-full threshold in words, 0..D (quasi-static)
//   wovf_clr    clears the sticky overflow flag
//   waddr       binary memory write address (combinational from wbin)
//   wptr        registered Gray write pointer for the read-domain sync
//   wfull       registered full flag
//   wafull      registered almost-full flag (level >= wafull_lvl)
//   wlevel      registered fill level 0..D as seen from the write side
//   woverflow   sticky: a write was attempted while full
// ---------------------------------------------------------------------------
module wptr_full_level #(
    parameter int addr_width = 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [addr_width:0]   wq2_rptr,
    input  logic [addr_width:0]   wafull_lvl,
    input  logic                  wovf_clr,
    output logic [addr_width-1:0] waddr,
    output logic [addr_width:0]   wptr,
    output logic                  wfull,
    output logic                  wafull,
    output logic [addr_width:0]   wlevel,
    output logic                  woverflow
);

    // Level value meaning "completely full": a single 1 in the pointer MSB.
    localparam logic [addr_width:0] depth = {1'b1, {addr_width{1'b0}}};

    logic [addr_width:0] wbin;
    logic [addr_width:0] wbinnext;
    logic [addr_width:0] wgraynext;
    logic [addr_width:0] rbin;
    logic [addr_width:0] levnext;

    assign waddr = wbin[addr_width-1:0];

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at and
    // above it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        rbin = '0;
        for (int i = 0; i <= addr_width; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    // The write is gated by the registered full flag, so a write requested
    // in the same cycle the read pointer frees a slot is still dropped; the
    // freed slot is seen one edge later.
    assign wbinnext  = wbin + {{addr_width{1'b0}}, (winc & ~wfull)};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;

    // Modulo subtraction stays correct across the pointer wrap because both
    // pointers carry one extra bit beyond the address. levnext == D is the
    // same condition as the classic Gray test (top two bits inverted, rest
    // equal).
    assign levnext   = wbinnext - rbin;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin      <= '0;
            wptr      <= '0;
            wlevel    <= '0;
            wfull     <= 1'b0;
            wafull    <= 1'b0;
            woverflow <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values, independent of statement order.
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            wlevel <= levnext;
            wfull  <= (levnext == depth);
            wafull <= (levnext >= wafull_lvl);
            // Set has priority over clear, so an overflow coinciding with a
            // clear request is never lost.
            if (winc && wfull) begin
                woverflow <= 1'b1;
            end else if (wovf_clr) begin
                woverflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wptr_full_level.sv
// ---------------------------------------------------------------------------
// tb_wptr_full_level
//
// Bench for wptr_full_level with addr_width=4. A reference model keeps plain
// integer counts of accepted writes and of read-pointer position and derives
// every expected output from them. Directed sequences cover reset, fill,
// overflow, almost-full threshold, wrap and the read-while-full corner; a
// randomized phase follows.
// ---------------------------------------------------------------------------
module tb_wptr_full_level;

    localparam int AW = 4;
    localparam int D  = 16;
    localparam int PM = 32;

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic          winc;
    logic [AW:0]   wq2_rptr;
    logic [AW:0]   wafull_lvl;
    logic          wovf_clr;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          wafull;
    logic [AW:0]   wlevel;
    logic          woverflow;

    wptr_full_level #(.addr_width(AW)) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .winc       (winc),
        .wq2_rptr   (wq2_rptr),
        .wafull_lvl (wafull_lvl),
        .wovf_clr   (wovf_clr),
        .waddr      (waddr),
        .wptr       (wptr),
        .wfull      (wfull),
        .wafull     (wafull),
        .wlevel     (wlevel),
        .woverflow  (woverflow)
    );

    always #5 wclk = ~wclk;

    int total = 0;
    int bad   = 0;

    // Reference model: total accepted writes and read position as counts.
    int m_wr;
    int m_rd;
    int m_level;
    bit m_full;
    bit m_afull;
    bit m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [AW:0] to_gray(input int v);
        logic [AW:0] b;
        b = (AW+1)'(v % PM);
        return (b >> 1) ^ b;
    endfunction

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_level = 0;
        m_full = 0; m_afull = 0; m_ovf = 0;
    endtask

    task automatic set_rd(input int v);
        m_rd     = v;
        wq2_rptr = to_gray(v);
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".waddr"},     32'(waddr),     32'(m_wr % D));
        check({ctx, ".wptr"},      32'(wptr),      32'(to_gray(m_wr)));
        check({ctx, ".wlevel"},    32'(wlevel),    32'(m_level));
        check({ctx, ".wfull"},     32'(wfull),     32'(m_full));
        check({ctx, ".wafull"},    32'(wafull),    32'(m_afull));
        check({ctx, ".woverflow"}, 32'(woverflow), 32'(m_ovf));
    endtask

    // One clock: update the model from the inputs present at the edge, then
    // compare all outputs 1 time unit later.
    task automatic tick(input string ctx);
        bit accept;
        bit ovf_n;
        @(posedge wclk);
        if (wrst_n) begin
            accept  = winc && !m_full;
            ovf_n   = (winc && m_full) ? 1'b1 : (wovf_clr ? 1'b0 : m_ovf);
            m_wr    = m_wr + int'(accept);
            m_level = (m_wr - m_rd) % PM;
            m_full  = (m_level == D);
            m_afull = (m_level >= int'(wafull_lvl));
            m_ovf   = ovf_n;
        end
        #1;
        check_all(ctx);
    endtask

    initial begin
        wrst_n     = 1'b0;
        winc       = 1'b0;
        wovf_clr   = 1'b0;
        wafull_lvl = 5'd12;
        wq2_rptr   = '0;
        model_reset();

        // Reset state.
        #3;
        check("rst.wptr",   32'(wptr),   0);
        check("rst.waddr",  32'(waddr),  0);
        check("rst.wfull",  32'(wfull),  0);
        check("rst.wafull", 32'(wafull), 0);
        check("rst.wlevel", 32'(wlevel), 0);
        check("rst.wovf",   32'(woverflow), 0);
        @(negedge wclk);
        wrst_n = 1'b1;
        tick("idle");

        // Fill from empty with threshold 12; wafull rises exactly at level 12.
        winc = 1'b1;
        for (int i = 1; i <= D; i++) begin
            tick("fill");
            if (i == 11) check("afull_below", 32'(wafull), 0);
            if (i == 12) check("afull_at_12", 32'(wafull), 1);
        end
        check("full16.wfull",  32'(wfull),  1);
        check("full16.wlevel", 32'(wlevel), 16);
        check("full16.wptr",   32'(wptr),   32'b11000);
        check("full16.waddr",  32'(waddr),  0);

        // Writes while full are dropped and set the sticky overflow flag.
        for (int i = 0; i < 3; i++) tick("ovf");
        check("ovf.wptr_hold", 32'(wptr), 32'b11000);
        check("ovf.set",       32'(woverflow), 1);
        winc = 1'b0;
        tick("ovf_hold");
        tick("ovf_hold");
        winc = 1'b1; wovf_clr = 1'b1;
        tick("ovf_setclr");
        check("ovf.set_wins", 32'(woverflow), 1);
        winc = 1'b0;
        tick("ovf_clr");
        check("ovf.cleared", 32'(woverflow), 0);
        wovf_clr = 1'b0;

        // Drain to empty; wafull falls when level reaches 11.
        for (int r = 1; r <= D; r++) begin
            set_rd(r);
            tick("drain");
            if (r == 4) check("afull_at_12_drain", 32'(wafull), 1);
            if (r == 5) check("afull_fall_11", 32'(wafull), 0);
        end

        // Wrap: 16 more writes bring wbin back to 0.
        winc = 1'b1;
        for (int i = 0; i < D; i++) tick("wrap");
        check("wrap.wptr",   32'(wptr),   0);
        check("wrap.waddr",  32'(waddr),  0);
        check("wrap.wfull",  32'(wfull),  1);
        check("wrap.wlevel", 32'(wlevel), 16);

        // Read advance while full and writing: write dropped this cycle,
        // full clears next edge, following write accepted.
        set_rd(D + 1);
        tick("rdfull");
        check("rdfull.wfull",  32'(wfull),  0);
        check("rdfull.wlevel", 32'(wlevel), 15);
        check("rdfull.waddr",  32'(waddr),  0);
        tick("rdfull_next");
        check("rdfull.accept", 32'(waddr), 1);
        check("rdfull.refull", 32'(wfull), 1);

        // Reset mid-burst: outputs clear immediately, not at the next edge.
        winc = 1'b0;
        set_rd(m_wr);
        tick("pre_burst");
        winc = 1'b1;
        tick("burst");
        tick("burst");
        #2;
        wrst_n = 1'b0;
        #1;
        check("midrst.waddr",  32'(waddr),  0);
        check("midrst.wptr",   32'(wptr),   0);
        check("midrst.wlevel", 32'(wlevel), 0);
        check("midrst.wfull",  32'(wfull),  0);
        check("midrst.wafull", 32'(wafull), 0);
        check("midrst.wovf",   32'(woverflow), 0);
        model_reset();
        wq2_rptr   = '0;
        winc       = 1'b0;
        wafull_lvl = 5'd0;
        tick("in_reset");
        @(negedge wclk);
        wrst_n = 1'b1;
        check("postrst.wafull_pre", 32'(wafull), 0);
        tick("postrst");
        check("postrst.wafull_lvl0", 32'(wafull), 1);

        // Randomized phase.
        for (int c = 0; c < 600; c++) begin
            winc     = 1'($urandom_range(0, 3) != 0);
            wovf_clr = 1'($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) wafull_lvl = 5'($urandom_range(0, D));
            if (m_rd < m_wr && $urandom_range(0, 2) == 0) set_rd(m_rd + 1);
            tick("rand");
            if (wafull_lvl == 5'(D)) check("rand.afull_eq_full", 32'(wafull), 32'(wfull));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
